// File: rtl/ps2_key_sequencer.sv
// ============================================================================
// Module  : ps2_key_sequencer
// Purpose : PS/2 keyboard receiver. Frames bytes off the raw lines, folds
//           F0/E0 prefixes into break/extended flags and queues key events.
//           Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]    C_BREAK   = 8'hF0;
    localparam logic [7:0]    C_EXT     = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // [0]/[1] are the synchroniser pair, [2] holds the previous synced value
    logic [2:0]    clk_s_q;
    logic [1:0]    dat_s_q;
    logic          w_fall;
    logic          w_din;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_vld_q, byte_vld_d;
    logic          ferr_q, ferr_d;
    logic          w_par_ok;

    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          w_push, w_pop, w_full, w_wr;

    assign w_fall = clk_s_q[2] & ~clk_s_q[1];
    assign w_din  = dat_s_q[1];

`ifdef PS2_PARITY_CHECK_EN
    logic par_q, par_d;
    // Odd parity: data plus parity bit must hold an odd number of ones
    assign w_par_ok = ^{shift_q, par_q};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            clk_s_q    <= 3'b111;
            dat_s_q    <= 2'b11;
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            bit_q      <= 3'd0;
            idle_q     <= '0;
            byte_q     <= 8'h00;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            clk_s_q    <= {clk_s_q[1:0], PS2_CLK};
            dat_s_q    <= {dat_s_q[0], PS2_DATA};
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            idle_q     <= idle_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            ferr_q     <= ferr_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;
        idle_d     = (w_fall || state_q == S_IDLE) ? '0 : idle_q + TW'(1);
`ifdef PS2_PARITY_CHECK_EN
        par_d      = par_q;
`endif
        if (w_fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!w_din) begin
                        state_d = S_SHIFT;
                        bit_d   = 3'd0;
                    end
                end
                S_SHIFT: begin
                    shift_d = {w_din, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d   = w_din;
`endif
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (w_din && w_par_ok) begin
                        byte_d     = shift_q;
                        byte_vld_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && idle_q == C_TO_LAST) begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            brk_q <= brk_d;
            ext_q <= ext_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            mem_q[wr_q] <= {byte_q, brk_q, ext_q};
        end
    end

    assign w_full = (cnt_q == C_DEPTH);
    assign w_pop  = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr   = w_push & (~w_full | w_pop);

    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        w_push = 1'b0;
        if (byte_vld_q) begin
            if (byte_q == C_BREAK) begin
                brk_d = 1'b1;
            end else if (byte_q == C_EXT) begin
                ext_d = 1'b1;
            end else begin
                w_push = 1'b1;
                brk_d  = 1'b0;
                ext_d  = 1'b0;
            end
        end
        if (ferr_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
        ovf_d = w_push & w_full & ~w_pop;
        cnt_d = cnt_q + (w_wr ? (AW+1)'(1) : '0) - (w_pop ? (AW+1)'(1) : '0);
        wr_d  = w_wr  ? wr_q + AW'(1) : wr_q;
        rd_d  = w_pop ? rd_q + AW'(1) : rd_q;
    end

    assign evt_valid = (cnt_q != '0);
    assign evt_code  = evt_valid ? mem_q[rd_q][9:2] : 8'h00;
    assign evt_break = evt_valid & mem_q[rd_q][1];
    assign evt_ext   = evt_valid & mem_q[rd_q][0];
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of key-event entries buffered (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the number of CLK cycles without a PS/2 falling edge after which a partial frame is abandoned.
REQ-003 SHALL have port CLK, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports PS2_CLK and PS2_DATA, input, 1 each, raw keyboard lines, asynchronous to CLK.
REQ-006 SHALL have port evt_valid, output, 1, high when the FIFO head holds an event.
REQ-007 SHALL have port evt_ready, input, 1, consumer accepts the head event.
REQ-008 SHALL have port evt_code, output, 8, scan code of the head event.
REQ-009 SHALL have ports evt_break and evt_ext, output, 1 each, head event was preceded by F0 and by E0 respectively.
REQ-010 SHALL have ports frame_err and overflow, output, 1 each, single-cycle error pulses.

Function
REQ-011 SHALL pass PS2_CLK and PS2_DATA through 2-flop synchronisers; a falling edge is synced-previous 1 and synced-current 0.
REQ-012 SHALL run frame FSM IDLE -> SHIFT -> PARITY -> STOP, advancing only on detected falling edges.
REQ-013 IDLE: a falling edge with data 0 enters SHIFT; a falling edge with data 1 is ignored.
REQ-014 SHIFT: SHALL sample 8 data bits LSB first, entering PARITY after the 8th.
REQ-015 PARITY: SHALL sample the parity bit and enter STOP.
REQ-016 STOP: stop bit 1 (and parity good, see REQ-027) SHALL deliver the byte to the decoder one cycle later; otherwise frame_err pulses; FSM returns to IDLE either way.
REQ-017 An idle counter SHALL clear on every falling edge; in any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE, discards the partial byte and pulses frame_err.
REQ-018 Decoder: byte F0 sets the break flag, byte E0 sets the extended flag, neither generates an event.
REQ-019 Decoder: any other byte pushes {code, break flag, ext flag} into the FIFO and clears both flags in the same cycle.
REQ-020 Both decoder flags SHALL clear on any frame_err.
REQ-021 Latency: with an empty FIFO, evt_valid SHALL assert exactly 2 CLK cycles after the cycle in which the stop-bit falling edge is detected.
REQ-022 A pop occurs when evt_valid and evt_ready are both high; evt_code/evt_break/evt_ext SHALL remain stable while evt_valid is high and evt_ready low.
REQ-023 Push to a full FIFO without a simultaneous pop SHALL drop the new event and pulse overflow for one cycle; push and pop in the same cycle while full SHALL both succeed without overflow.
REQ-024 Empty FIFO: evt_valid 0, evt_ready ignored; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-025 reset high SHALL immediately force: FSM IDLE, shift/bit counters 0, idle counter 0, synchronisers 1, decoder flags 0, FIFO empty.
REQ-026 During reset all outputs SHALL be 0 (evt_valid, evt_code 8'h00, evt_break, evt_ext, frame_err, overflow); a frame in progress at reset SHALL be discarded with no frame_err.

Configuration
REQ-027 With PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit hold an even number of ones SHALL be rejected with frame_err; without it, the parity bit is sampled and ignored.

Verification (FIFO_DEPTH 4, TIMEOUT_CYCLES 2000, PS/2 half-period 100 CLK)
REQ-028 Send 1C (parity 0) -> one event code 1C, break 0, ext 0, evt_valid 2 cycles after stop edge.
REQ-029 Send F0, 1C -> exactly one event code 1C, break 1, ext 0; send E0, F0, 75 -> one event code 75, break 1, ext 1.
REQ-030 evt_ready held 0, send 5 make codes 16,1E,26,25,2E -> overflow pulses once on 2E; then popping returns 16,1E,26,25 in order.
REQ-031 Send start bit plus 4 data bits then stop clocking -> frame_err pulse 2000 cycles after last edge, FSM IDLE, next full frame 5A decodes correctly.
REQ-032 With PS2_PARITY_CHECK_EN, send 1C with parity 1 -> frame_err, no event; without the macro -> event 1C.
REQ-033 Assert reset mid-frame after F0 received -> outputs 0, FIFO empty, next frame 1C yields break 0.
